// File: rtl/pipelined_cla_addsub_if.sv
// Stream bundle for pipelined_cla_addsub: operand/request side plus result side.
// The ovf signal exists only when OVERFLOW_FLAG_EN is defined.
interface pipelined_cla_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout
  );
`endif
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one SEG-bit segment resolved per stage.
// Optional signed-overflow flag enabled by defining OVERFLOW_FLAG_EN.
module pipelined_cla_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_cla_addsub_if.slave bus
);
  localparam int unsigned NSEG = (SEG == 0) ? 1 : WIDTH / SEG;

  generate
    if (SEG == 0 || (WIDTH % SEG) != 0) begin : g_bad_cfg
      $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of SEG");
    end
  endgenerate

  // Returns {carry into segment MSB, carry out, SEG-bit sum}.
  // Each carry is a flat sum-of-products of generate/propagate terms.
  function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c0);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           term;
    logic           acc;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int unsigned i = 0; i < SEG; i++) begin
      term = c0;
      for (int unsigned m = 0; m <= i; m++) term = term & p[m];
      acc = term;
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
    return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic             adv;
  logic [NSEG-1:0]  v_r;
  logic [WIDTH-1:0] sum_r [NSEG];
  logic [WIDTH-1:0] a_r   [NSEG];
  logic [WIDTH-1:0] bp_r  [NSEG];
  logic             c_r   [NSEG];

  logic [WIDTH-1:0] src_a [NSEG];
  logic [WIDTH-1:0] src_b [NSEG];
  logic [WIDTH-1:0] src_s [NSEG];
  logic             src_c [NSEG];
  logic [SEG+1:0]   seg_res [NSEG];
  logic [WIDTH-1:0] sum_n [NSEG];

  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  // Stage k consumes the registers of stage k-1; stage 0 consumes the live inputs.
  always_comb begin
    src_a[0] = bus.a;
    src_b[0] = bus.sub ? ~bus.b : bus.b;
    src_c[0] = bus.sub | bus.cin;
    src_s[0] = '0;
    for (int unsigned k = 1; k < NSEG; k++) begin
      src_a[k] = a_r[k-1];
      src_b[k] = bp_r[k-1];
      src_c[k] = c_r[k-1];
      src_s[k] = sum_r[k-1];
    end
    for (int unsigned k = 0; k < NSEG; k++) begin
      seg_res[k]              = cla_seg(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_c[k]);
      sum_n[k]                = src_s[k];
      sum_n[k][k*SEG +: SEG]  = seg_res[k][SEG-1:0];
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic ovf_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (adv) begin
      ovf_r <= seg_res[NSEG-1][SEG+1] ^ seg_res[NSEG-1][SEG];
    end
  end
  assign bus.ovf = ovf_r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= '0;
      for (int unsigned k = 0; k < NSEG; k++) begin
        sum_r[k] <= '0;
        a_r[k]   <= '0;
        bp_r[k]  <= '0;
        c_r[k]   <= 1'b0;
      end
    end else if (adv) begin
      v_r[0] <= bus.in_valid;
      for (int unsigned k = 1; k < NSEG; k++) v_r[k] <= v_r[k-1];
      for (int unsigned k = 0; k < NSEG; k++) begin
        sum_r[k] <= sum_n[k];
        a_r[k]   <= src_a[k];
        bp_r[k]  <= src_b[k];
        c_r[k]   <= seg_res[k][SEG];
      end
    end
  end

  assign bus.out_valid = v_r[NSEG-1];
  assign bus.s         = sum_r[NSEG-1];
  assign bus.cout      = c_r[NSEG-1];
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub at WIDTH=32, SEG=8 (four stages).
// Overflow checks are compiled in when OVERFLOW_FLAG_EN is defined.
module tb_pipelined_cla_addsub;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  pipelined_cla_addsub_if #(.WIDTH(32)) bus ();

  pipelined_cla_addsub #(.WIDTH(32), .SEG(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] tab_a [6] = '{32'h0000_0001, 32'h0000_00FF, 32'h0000_FFFF,
                             32'h0001_0000, 32'h00FF_FFFF, 32'h0000_0000};
  logic [31:0] tab_b [6] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0001,
                             32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
  logic        tab_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] tab_s [6] = '{32'h0000_0003, 32'h0000_0100, 32'h0001_0000,
                             32'h0000_FFFF, 32'h0100_0000, 32'hFFFF_FFFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int idx);
    bus.in_valid = 1'b1;
    bus.a        = tab_a[idx];
    bus.b        = tab_b[idx];
    bus.sub      = tab_sub[idx];
    bus.cin      = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [31:0] exp_s,
                         input logic exp_c, input logic exp_o);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_early_valid"}, {31'b0, bus.out_valid}, 32'd0);
      tick();
    end
    chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({tag, "_s"}, bus.s, exp_s);
    chk({tag, "_cout"}, {31'b0, bus.cout}, {31'b0, exp_c});
`ifdef OVERFLOW_FLAG_EN
    chk({tag, "_ovf"}, {31'b0, bus.ovf}, {31'b0, exp_o});
`else
    if (exp_o === 1'bx) $display("unexpected unknown overflow expectation in %s", tag);
`endif
    tick();
    chk({tag, "_after_valid"}, {31'b0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_s", bus.s, 32'd0);
    chk("rst_cout", {31'b0, bus.cout}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
`ifdef OVERFLOW_FLAG_EN
    chk("rst_ovf", {31'b0, bus.ovf}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Single operations through an otherwise empty pipe
    run_one("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_one("sub_borrow",32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_pos",   32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run_one("sub_cin_ig",32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run_one("add_cin",   32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0);
    run_one("add_ovf_p", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("sub_ovf_n", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_one("add_neg2",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // Six back-to-back operations, out_ready held high
    for (int i = 0; i < 6; i++) begin
      present(i);
      tick();
      if (i >= 3) begin
        chk("b2b_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("b2b_s", bus.s, tab_s[i-3]);
      end else begin
        chk("b2b_fill_valid", {31'b0, bus.out_valid}, 32'd0);
      end
    end
    bus.in_valid = 1'b0;
    for (int i = 3; i < 6; i++) begin
      tick();
      chk("b2b_tail_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("b2b_tail_s", bus.s, tab_s[i]);
    end
    tick();
    chk("b2b_drained", {31'b0, bus.out_valid}, 32'd0);

    // Fill the pipe, then stall the output for three cycles
    for (int i = 0; i < 4; i++) begin
      present(i);
      tick();
    end
    present(4);
    bus.out_ready = 1'b0;
    #1;
    chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_s_held", bus.s, tab_s[0]);
      chk("stall_in_ready_hold", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk("release_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("release_s", bus.s, tab_s[i]);
      tick();
    end
    chk("release_drained", {31'b0, bus.out_valid}, 32'd0);

    // Reset with three operations in flight, the oldest already at the output
    for (int i = 0; i < 3; i++) begin
      present(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    #2;
    chk("rst_async_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_async_s", bus.s, 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_quiet", {31'b0, bus.out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
